rob_dual_commit: RTL and testbench

- Parametrised reorder buffer with DEPTH entries and WB_CH writeback channels.
- Retires up to two instructions per cycle and forwards same-cycle writebacks to operand lookups at issue.
- Self-flushes on a committed mispredict.
- Sits between issue/decode, the ALU and load-store buffer writeback paths, the register file, the LSB store-commit port, the fetch redirect path and the branch predictor.

---
 rtl/rob_pkg.sv | 19 +
 rtl/rob_commit_sel.sv | 39 +++
 rtl/rob_dual_commit.sv | 213 +++++++++++++++++++++
 tb/tb_rob_dual_commit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the dual-commit reorder buffer: entry classes and the
// per-entry control record.
package rob_pkg;

  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JUMP   = 2'd2,
    KIND_STORE  = 2'd3
  } kind_t;

  typedef struct packed {
    kind_t           kind;
    logic [RD_W-1:0] rd;
  } entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Retire-slot selection: decides what the head (and head+1) entries retire as
// this cycle, and whether the head control transfer was mispredicted.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              head_valid,
  input  logic              pair_valid,
  input  logic              head_done,
  input  kind_t             head_kind,
  input  logic [DATA_W-1:0] head_pc,
  input  logic [DATA_W-1:0] head_pred_pc,
  input  logic [DATA_W-1:0] head_target,
  input  logic              nxt_done,
  input  kind_t             nxt_kind,
  output logic              slot0,
  output logic              slot1,
  output logic              slot0_wr,
  output logic              slot0_store,
  output logic              slot0_branch,
  output logic              mispredict,
  output logic              taken
);

  always_comb begin
    slot0        = head_valid && head_done;
    slot0_wr     = slot0 && (head_kind == KIND_REG || head_kind == KIND_JUMP);
    slot0_store  = slot0 && (head_kind == KIND_STORE);
    slot0_branch = slot0 && (head_kind == KIND_BRANCH);
    // The second slot only pairs two plain register writes.
    slot1        = slot0 && (head_kind == KIND_REG) && pair_valid && nxt_done
                   && (nxt_kind == KIND_REG);
    mispredict   = slot0 && (head_kind == KIND_JUMP || head_kind == KIND_BRANCH)
                   && (head_target != head_pred_pc);
    taken        = head_target != (head_pc + DATA_W'(4));
  end

endmodule

// File: rtl/rob_dual_commit.sv
// Reorder buffer retiring up to two entries per cycle, with writeback
// forwarding to operand lookups and self-flush on a committed mispredict.
module rob_dual_commit
  import rob_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int WB_CH     = 2,
  parameter int DATA_W    = 32,
  parameter int LSB_IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ready,
  input  logic                    clear,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  output logic [IDX_W-1:0]        alloc_idx,
  input  logic [1:0]              push_kind,
  input  logic [4:0]              push_rd,
  input  logic [DATA_W-1:0]       push_pc,
  input  logic [DATA_W-1:0]       push_pred_pc,
  input  logic [LSB_IDX_W-1:0]    push_lsb_idx,
  input  logic [WB_CH-1:0]        wb_valid,
  input  logic [WB_CH*IDX_W-1:0]  wb_idx,
  input  logic [WB_CH*DATA_W-1:0] wb_val,
  input  logic [WB_CH*DATA_W-1:0] wb_target,
  input  logic [IDX_W-1:0]        src1_idx,
  input  logic [IDX_W-1:0]        src2_idx,
  output logic                    src1_ok,
  output logic                    src2_ok,
  output logic [DATA_W-1:0]       src1_val,
  output logic [DATA_W-1:0]       src2_val,
  output logic [1:0]              cm_valid,
  output logic [9:0]              cm_rd,
  output logic [2*IDX_W-1:0]      cm_idx,
  output logic [2*DATA_W-1:0]     cm_val,
  output logic                    st_commit,
  output logic [LSB_IDX_W-1:0]    st_lsb_idx,
  output logic [IDX_W-1:0]        rob_head,
  output logic                    jump,
  output logic [DATA_W-1:0]       pc_jumpto,
  output logic                    rob_clear,
  output logic                    pred_upd,
  output logic [DATA_W-1:0]       pred_upd_pc,
  output logic                    pred_res
);

  logic [IDX_W-1:0]     head, tail, head_nxt;
  logic [IDX_W:0]       count;
  logic [DEPTH-1:0]     done, done_next;
  entry_t               ctl    [DEPTH];
  logic [DATA_W-1:0]    pc_q   [DEPTH];
  logic [DATA_W-1:0]    pred_q [DEPTH];
  logic [DATA_W-1:0]    val_q  [DEPTH];
  logic [DATA_W-1:0]    tgt_q  [DEPTH];
  logic [LSB_IDX_W-1:0] lsb_q  [DEPTH];

  logic [WB_CH-1:0] wb_hit;
  logic [IDX_W-1:0] wb_i [WB_CH];
  logic [IDX_W-1:0] wb_off;
  logic             push_ok;
  logic [1:0]       n_commit;
  logic slot0, slot1, slot0_wr, slot0_store, slot0_branch, mispredict, taken;

  assign head_nxt    = head + IDX_W'(1);
  assign alloc_ready = count != (IDX_W+1)'(DEPTH);
  assign alloc_idx   = tail;
  assign rob_head    = head;
  assign push_ok     = alloc_valid && alloc_ready && !mispredict;
  assign n_commit    = {1'b0, slot0} + {1'b0, slot1};

  rob_commit_sel #(.DATA_W(DATA_W)) u_sel (
    .head_valid   (count != '0),
    .pair_valid   (count >= (IDX_W+1)'(2)),
    .head_done    (done[head]),
    .head_kind    (ctl[head].kind),
    .head_pc      (pc_q[head]),
    .head_pred_pc (pred_q[head]),
    .head_target  (tgt_q[head]),
    .nxt_done     (done[head_nxt]),
    .nxt_kind     (ctl[head_nxt].kind),
    .slot0        (slot0),
    .slot1        (slot1),
    .slot0_wr     (slot0_wr),
    .slot0_store  (slot0_store),
    .slot0_branch (slot0_branch),
    .mispredict   (mispredict),
    .taken        (taken)
  );

  // A writeback only lands if its index lies inside the live head..tail window.
  always_comb begin
    wb_hit = '0;
    wb_off = '0;
    for (int c = 0; c < WB_CH; c++) begin
      wb_i[c]   = wb_idx[c*IDX_W +: IDX_W];
      wb_off    = wb_i[c] - head;
      wb_hit[c] = wb_valid[c] && ({1'b0, wb_off} < count);
    end
  end

  always_comb begin
    done_next = done;
    if (slot0) done_next[head] = 1'b0;
    if (slot1) done_next[head_nxt] = 1'b0;
    for (int c = 0; c < WB_CH; c++)
      if (wb_hit[c]) done_next[wb_i[c]] = 1'b1;
    if (push_ok) done_next[tail] = (push_kind == KIND_STORE);
  end

  always_comb begin
    src1_ok  = 1'b0;
    src1_val = '0;
    src2_ok  = 1'b0;
    src2_val = '0;
    if (done[src1_idx]) begin
      src1_ok  = 1'b1;
      src1_val = val_q[src1_idx];
    end else begin
      for (int c = 0; c < WB_CH; c++)
        if (wb_valid[c] && wb_idx[c*IDX_W +: IDX_W] == src1_idx) begin
          src1_ok  = 1'b1;
          src1_val = wb_val[c*DATA_W +: DATA_W];
        end
    end
    if (done[src2_idx]) begin
      src2_ok  = 1'b1;
      src2_val = val_q[src2_idx];
    end else begin
      for (int c = 0; c < WB_CH; c++)
        if (wb_valid[c] && wb_idx[c*IDX_W +: IDX_W] == src2_idx) begin
          src2_ok  = 1'b1;
          src2_val = wb_val[c*DATA_W +: DATA_W];
        end
    end
  end

  // Payload storage needs no reset: done/count gate every use of it.
  always_ff @(posedge clk) begin
    if (ready && !clear) begin
      for (int c = 0; c < WB_CH; c++)
        if (wb_hit[c]) begin
          val_q[wb_i[c]] <= wb_val[c*DATA_W +: DATA_W];
          tgt_q[wb_i[c]] <= wb_target[c*DATA_W +: DATA_W];
        end
      if (push_ok) begin
        ctl[tail]    <= '{kind: kind_t'(push_kind), rd: push_rd};
        pc_q[tail]   <= push_pc;
        pred_q[tail] <= push_pred_pc;
        lsb_q[tail]  <= push_lsb_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      done        <= '0;
      cm_valid    <= '0;
      cm_rd       <= '0;
      cm_idx      <= '0;
      cm_val      <= '0;
      st_commit   <= 1'b0;
      st_lsb_idx  <= '0;
      jump        <= 1'b0;
      pc_jumpto   <= '0;
      rob_clear   <= 1'b0;
      pred_upd    <= 1'b0;
      pred_upd_pc <= '0;
      pred_res    <= 1'b0;
    end else if (clear || !ready) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        done  <= '0;
      end
      cm_valid  <= '0;
      st_commit <= 1'b0;
      jump      <= 1'b0;
      rob_clear <= 1'b0;
      pred_upd  <= 1'b0;
    end else begin
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        done  <= '0;
      end else begin
        head  <= head + IDX_W'(n_commit);
        tail  <= tail + IDX_W'(push_ok);
        count <= count + (IDX_W+1)'(push_ok) - (IDX_W+1)'(n_commit);
        done  <= done_next;
      end
      cm_valid    <= {slot1, slot0_wr};
      cm_rd       <= {ctl[head_nxt].rd, ctl[head].rd};
      cm_idx      <= {head_nxt, head};
      cm_val      <= {val_q[head_nxt], val_q[head]};
      st_commit   <= slot0_store;
      st_lsb_idx  <= lsb_q[head];
      jump        <= mispredict;
      rob_clear   <= mispredict;
      pc_jumpto   <= tgt_q[head];
      pred_upd    <= slot0_branch;
      pred_upd_pc <= pc_q[head];
      pred_res    <= slot0_branch && taken;
    end
  end

endmodule

// File: tb/tb_rob_dual_commit.sv
// Directed bench for rob_dual_commit: reset, dual retire, branch/jump resolve,
// full-buffer boundary, forwarding, store ordering and stall behaviour.
module tb_rob_dual_commit;
  import rob_pkg::*;

  localparam int DEPTH = 16, IDX_W = 4, WB_CH = 2, DATA_W = 32, LSB_IDX_W = 4;

  logic clk = 1'b0, reset = 1'b1, ready = 1'b1, clear = 1'b0;
  logic alloc_valid = 1'b0, alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic [1:0] push_kind = 2'd0;
  logic [4:0] push_rd = '0;
  logic [DATA_W-1:0] push_pc = '0, push_pred_pc = '0;
  logic [LSB_IDX_W-1:0] push_lsb_idx = '0;
  logic [WB_CH-1:0] wb_valid = '0;
  logic [WB_CH*IDX_W-1:0] wb_idx = '0;
  logic [WB_CH*DATA_W-1:0] wb_val = '0, wb_target = '0;
  logic [IDX_W-1:0] src1_idx = '0, src2_idx = '0;
  logic src1_ok, src2_ok;
  logic [DATA_W-1:0] src1_val, src2_val;
  logic [1:0] cm_valid;
  logic [9:0] cm_rd;
  logic [2*IDX_W-1:0] cm_idx;
  logic [2*DATA_W-1:0] cm_val;
  logic st_commit;
  logic [LSB_IDX_W-1:0] st_lsb_idx;
  logic [IDX_W-1:0] rob_head;
  logic jump, rob_clear, pred_upd, pred_res;
  logic [DATA_W-1:0] pc_jumpto, pred_upd_pc;

  int n_checks = 0, n_errors = 0;

  rob_dual_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_CH(WB_CH), .DATA_W(DATA_W),
                    .LSB_IDX_W(LSB_IDX_W)) dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .push_kind(push_kind), .push_rd(push_rd), .push_pc(push_pc),
    .push_pred_pc(push_pred_pc), .push_lsb_idx(push_lsb_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .wb_target(wb_target),
    .src1_idx(src1_idx), .src2_idx(src2_idx), .src1_ok(src1_ok), .src2_ok(src2_ok),
    .src1_val(src1_val), .src2_val(src2_val),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_idx(cm_idx), .cm_val(cm_val),
    .st_commit(st_commit), .st_lsb_idx(st_lsb_idx), .rob_head(rob_head),
    .jump(jump), .pc_jumpto(pc_jumpto), .rob_clear(rob_clear),
    .pred_upd(pred_upd), .pred_upd_pc(pred_upd_pc), .pred_res(pred_res)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                      input logic [31:0] ppc, input logic [3:0] lsb);
    alloc_valid  = 1'b1;
    push_kind    = kind;
    push_rd      = rd;
    push_pc      = pc;
    push_pred_pc = ppc;
    push_lsb_idx = lsb;
    tick();
    alloc_valid  = 1'b0;
  endtask

  task automatic wb(input int ch, input logic [3:0] idx, input logic [31:0] val,
                    input logic [31:0] tgt);
    wb_valid[ch] = 1'b1;
    wb_idx[ch*IDX_W +: IDX_W] = idx;
    wb_val[ch*DATA_W +: DATA_W] = val;
    wb_target[ch*DATA_W +: DATA_W] = tgt;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_cm_valid", cm_valid, 0);

    // Reset mid-run with five live entries
    for (int i = 0; i < 5; i++) push(2'd0, 5'(i + 1), 32'h0, 32'h0, 4'h0);
    chk("pre_rst_alloc_idx", alloc_idx, 5);
    reset = 1'b1;
    #2;
    chk("async_rst_alloc_idx", alloc_idx, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_alloc_idx", alloc_idx, 0);
    chk("midrst_alloc_ready", alloc_ready, 1);
    chk("midrst_strobes", {cm_valid, st_commit, jump, rob_clear, pred_upd}, 0);
    chk("midrst_head", rob_head, 0);

    // Dual retire of two register writes
    push(2'd0, 5'd3, 32'h0, 32'h4, 4'h0);
    push(2'd0, 5'd4, 32'h4, 32'h8, 4'h0);
    wb(0, 4'd0, 32'h11, 32'h0);
    wb(1, 4'd1, 32'h22, 32'h0);
    tick();
    wb_valid = '0;
    tick();
    chk("dual_cm_valid", cm_valid, 2'b11);
    chk("dual_cm_rd", cm_rd, {5'd4, 5'd3});
    chk("dual_cm_val", cm_val, {32'h22, 32'h11});
    chk("dual_cm_idx", cm_idx, {4'd1, 4'd0});
    chk("dual_head", rob_head, 2);
    tick();
    chk("dual_cm_valid_off", cm_valid, 0);

    // Correctly predicted jump: register write, no redirect
    push(2'd2, 5'd1, 32'h40, 32'h80, 4'h0);
    wb(0, 4'd2, 32'h44, 32'h80);
    tick();
    wb_valid = '0;
    tick();
    chk("jmp_cm_valid", cm_valid, 2'b01);
    chk("jmp_cm_val", cm_val[31:0], 32'h44);
    chk("jmp_no_redirect", {jump, rob_clear, pred_upd}, 0);

    // Not-taken branch predicted correctly
    push(2'd1, 5'd0, 32'h100, 32'h104, 4'h0);
    wb(0, 4'd3, 32'h0, 32'h104);
    tick();
    wb_valid = '0;
    tick();
    chk("bnt_pred_upd", {pred_upd, pred_res}, 2'b10);
    chk("bnt_pred_pc", pred_upd_pc, 32'h100);
    chk("bnt_no_jump", {jump, cm_valid}, 0);

    // Taken branch mispredicted; a push in the resolving cycle is dropped
    push(2'd1, 5'd0, 32'h100, 32'h104, 4'h0);
    wb(0, 4'd4, 32'h0, 32'h200);
    tick();
    wb_valid = '0;
    alloc_valid = 1'b1;
    push_kind = 2'd0;
    push_rd = 5'd9;
    tick();
    alloc_valid = 1'b0;
    chk("bmis_pred", {pred_upd, pred_res}, 2'b11);
    chk("bmis_jump", {jump, rob_clear}, 2'b11);
    chk("bmis_target", pc_jumpto, 32'h200);
    chk("bmis_alloc_idx", alloc_idx, 0);
    chk("bmis_head", rob_head, 0);
    tick();
    chk("bmis_pulse_off", {jump, rob_clear, pred_upd}, 0);

    // Same-cycle forwarding and channel priority
    push(2'd0, 5'd5, 32'h0, 32'h0, 4'h0);
    push(2'd0, 5'd6, 32'h0, 32'h0, 4'h0);
    push(2'd0, 5'd7, 32'h0, 32'h0, 4'h0);
    src1_idx = 4'd2;
    src2_idx = 4'd1;
    wb(1, 4'd2, 32'h55, 32'h0);
    #1;
    chk("fwd_src1", {src1_ok, src1_val}, {1'b1, 32'h55});
    chk("fwd_src2_pending", {src2_ok, src2_val}, {1'b0, 32'h0});
    wb(0, 4'd2, 32'h66, 32'h0);
    wb(1, 4'd2, 32'h77, 32'h0);
    #1;
    chk("fwd_prio", {src1_ok, src1_val}, {1'b1, 32'h77});
    tick();
    wb_valid = '0;
    #1;
    chk("stored_prio", {src1_ok, src1_val}, {1'b1, 32'h77});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clear_done", src1_ok, 0);
    chk("clear_alloc", {alloc_ready, alloc_idx}, {1'b1, 4'd0});
    chk("clear_pulses", {cm_valid, st_commit, jump, rob_clear, pred_upd}, 0);

    // Store at head with a done register write behind it
    push(2'd0, 5'd10, 32'h0, 32'h0, 4'h0);
    push(2'd3, 5'd0, 32'h0, 32'h0, 4'd9);
    push(2'd0, 5'd11, 32'h0, 32'h0, 4'h0);
    wb(0, 4'd2, 32'hB0, 32'h0);
    wb(1, 4'd0, 32'hA0, 32'h0);
    tick();
    wb_valid = '0;
    tick();
    chk("st_first_reg", {cm_valid, cm_rd[4:0], st_commit}, {2'b01, 5'd10, 1'b0});
    tick();
    chk("st_commit", {st_commit, st_lsb_idx, cm_valid}, {1'b1, 4'd9, 2'b00});
    tick();
    chk("st_after_reg", {cm_valid, cm_rd[4:0], st_commit}, {2'b01, 5'd11, 1'b0});
    chk("st_after_val", cm_val[31:0], 32'hB0);

    // Fill to full; pushes while full are dropped
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(2'd0, 5'(i + 1), 32'h0, 32'h0, 4'h0);
    chk("full_alloc", {alloc_ready, alloc_idx}, {1'b0, 4'd0});
    alloc_valid = 1'b1;
    push_kind = 2'd3;
    push_rd = 5'd31;
    push_lsb_idx = 4'd7;
    wb(0, 4'd0, 32'hAB, 32'h0);
    tick();
    wb_valid = '0;
    push_kind = 2'd0;
    push_rd = 5'd20;
    chk("full_still", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0;
    chk("full_commit", {cm_valid, cm_rd[4:0], st_commit}, {2'b01, 5'd1, 1'b0});
    chk("full_commit_val", cm_val[31:0], 32'hAB);
    chk("full_after", {alloc_ready, alloc_idx, rob_head}, {1'b1, 4'd0, 4'd1});

    // ready low freezes retire
    wb(0, 4'd1, 32'hC1, 32'h0);
    tick();
    wb_valid = '0;
    ready = 1'b0;
    tick();
    chk("stall_no_commit", {cm_valid, rob_head}, {2'b00, 4'd1});
    ready = 1'b1;
    tick();
    chk("stall_release", {cm_valid, cm_rd[4:0], rob_head}, {2'b01, 5'd2, 4'd2});
    chk("stall_release_val", cm_val[31:0], 32'hC1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
